// File: rtl/mulpool_pkg.sv
// Shared definitions for the multiplier-pool scheduler.
//   state_e    : scheduler FSM states (IDLE, ISSUE, WAIT, RESP), 2-bit encoding
//   clog2      : index width helper, never returns less than 1
//   cnt_width  : watchdog counter width able to hold the value TIMEOUT
package mulpool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 32'sd1;
        end
        if (result < 32'sd1) begin
            result = 32'sd1;
        end else begin
            result = result;
        end
        return result;
    endfunction

    function automatic int cnt_width(input int timeout);
        return clog2(timeout + 32'sd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req         : request vector, one bit per requester
//   ptr         : index with highest priority this cycle
//   advance     : enables the grant; grant is all-zero when low
//   grant       : one-hot grant
//   grant_idx   : binary index of the granted requester
//   grant_valid : a grant is being issued
module rr_arbiter
    import mulpool_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_valid
);

    logic [IW:0]   sum_s;
    logic [IW-1:0] cand_s;

    // Scan requesters from ptr upwards, wrapping modulo NREQ; first hit wins.
    always_comb begin
        grant       = {NREQ{1'b0}};
        grant_idx   = {IW{1'b0}};
        grant_valid = 1'b0;
        sum_s       = {(IW+1){1'b0}};
        cand_s      = {IW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sum_s = {1'b0, ptr} + (IW+1)'(i);
            if (sum_s >= (IW+1)'(NREQ)) begin
                cand_s = IW'(sum_s - (IW+1)'(NREQ));
            end else begin
                cand_s = sum_s[IW-1:0];
            end
            if (advance && !grant_valid && req[cand_s]) begin
                grant_valid    = 1'b1;
                grant_idx      = cand_s;
                grant[cand_s]  = 1'b1;
            end else begin
                grant_valid    = grant_valid;
            end
        end
    end

endmodule

// File: rtl/mulpool_sched.sv
// Round-robin scheduler sharing one modular multiplier among NREQ requesters.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester request / one-hot accept (IDLE only)
//   req_a, req_b        : flat operands, requester i at [i*NBITS +: NBITS]
//   m                   : modulus, sampled on accept
//   rsp_valid           : one-hot, one-cycle result strobe
//   rsp_y, rsp_err      : result and timeout flag, held until next response
//   busy, grant_id      : not-IDLE indicator, current/last granted requester
//   mm_enable_p         : one-cycle start pulse to the multiplier
//   mm_a/mm_b/mm_m/mm_mx3 : registered operands and 3*m for the multiplier
//   mm_y, mm_done_p     : multiplier result and completion pulse
module mulpool_sched
    import mulpool_pkg::*;
#(
    parameter  int NBITS   = 128,
    parameter  int PBITS   = 2,
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 255,
    localparam int IW      = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*NBITS-1:0] req_a,
    input  logic [NREQ*NBITS-1:0] req_b,
    input  logic [NBITS-1:0]      m,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [NBITS-1:0]      rsp_y,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [IW-1:0]         grant_id,
    output logic                  mm_enable_p,
    output logic [NBITS-1:0]      mm_a,
    output logic [NBITS-1:0]      mm_b,
    output logic [NBITS-1:0]      mm_m,
    output logic [NBITS+PBITS-1:0] mm_mx3,
    input  logic [NBITS-1:0]      mm_y,
    input  logic                  mm_done_p
);

    localparam int CW = cnt_width(TIMEOUT);

    state_e                 state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          grant_id_q, grant_id_d;
    logic [NBITS-1:0]       a_q, a_d, b_q, b_d, m_q, m_d;
    logic [NBITS+PBITS-1:0] mx3_q, mx3_d;
    logic                   enable_q, enable_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [NBITS-1:0]       rsp_y_q, rsp_y_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   busy_q, busy_d;

    logic [NREQ-1:0]        arb_grant_s;
    logic [IW-1:0]          arb_idx_s;
    logic                   arb_any_s;
    logic                   arb_adv_s;
    logic [NBITS+1:0]       mx3_full_s;
    logic [CW-1:0]          cnt_inc_s;

    // Grants are only offered in IDLE and never while reset is applied.
    assign arb_adv_s = (state_q == ST_IDLE) && !rst;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr_q),
        .advance     (arb_adv_s),
        .grant       (arb_grant_s),
        .grant_idx   (arb_idx_s),
        .grant_valid (arb_any_s)
    );

    // 3*m = m + 2*m, exact in NBITS+2 bits before resizing to the mx3 port.
    assign mx3_full_s = {2'b00, m} + {1'b0, m, 1'b0};
    assign cnt_inc_s  = cnt_q + CW'(1);

    // Next-state and next-output computation for the scheduler FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        a_d         = a_q;
        b_d         = b_q;
        m_d         = m_q;
        mx3_d       = mx3_q;
        enable_d    = 1'b0;
        cnt_d       = cnt_q;
        rsp_valid_d = {NREQ{1'b0}};
        rsp_y_d     = rsp_y_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any_s) begin
                    a_d        = req_a[int'(arb_idx_s)*NBITS +: NBITS];
                    b_d        = req_b[int'(arb_idx_s)*NBITS +: NBITS];
                    m_d        = m;
                    mx3_d      = (NBITS+PBITS)'(mx3_full_s);
                    grant_id_d = arb_idx_s;
                    if (arb_idx_s == IW'(NREQ - 1)) begin
                        ptr_d = {IW{1'b0}};
                    end else begin
                        ptr_d = arb_idx_s + IW'(1);
                    end
                    enable_d   = 1'b1;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = {CW{1'b0}};
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_inc_s;
                // Completion takes priority over an expiring watchdog.
                if (mm_done_p) begin
                    rsp_y_d                 = mm_y;
                    rsp_err_d               = 1'b0;
                    rsp_valid_d[grant_id_q] = 1'b1;
                    state_d                 = ST_RESP;
                end else if (cnt_inc_s == CW'(TIMEOUT)) begin
                    rsp_y_d                 = {NBITS{1'b0}};
                    rsp_err_d               = 1'b1;
                    rsp_valid_d[grant_id_q] = 1'b1;
                    state_d                 = ST_RESP;
                end else begin
                    state_d                 = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= {IW{1'b0}};
            grant_id_q  <= {IW{1'b0}};
            a_q         <= {NBITS{1'b0}};
            b_q         <= {NBITS{1'b0}};
            m_q         <= {NBITS{1'b0}};
            mx3_q       <= {(NBITS+PBITS){1'b0}};
            enable_q    <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            rsp_valid_q <= {NREQ{1'b0}};
            rsp_y_q     <= {NBITS{1'b0}};
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            m_q         <= m_d;
            mx3_q       <= mx3_d;
            enable_q    <= enable_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready   = arb_grant_s;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_y       = rsp_y_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign mm_enable_p = enable_q;
    assign mm_a        = a_q;
    assign mm_b        = b_q;
    assign mm_m        = m_q;
    assign mm_mx3      = mx3_q;

endmodule

// File: tb/tb_mulpool_sched.sv
// Self-checking bench for mulpool_sched (NBITS=16, NREQ=4, TIMEOUT=20) with a
// behavioural modular multiplier of programmable latency.
module tb_mulpool_sched;

    localparam int NB = 16;
    localparam int PB = 2;
    localparam int NR = 4;
    localparam int TO = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid;
    logic [NR*NB-1:0]  req_a, req_b;
    logic [NB-1:0]     m, rsp_y, mm_a, mm_b, mm_m, mm_y;
    logic              rsp_err, busy, mm_enable_p, mm_done_p;
    logic [1:0]        grant_id;
    logic [NB+PB-1:0]  mm_mx3;

    int total = 0;
    int bad   = 0;
    int exp_ptr = 0;

    // multiplier stub state
    int          stub_lat  = -1;
    bit          stub_hang = 1'b0;
    bit          late_pulse = 1'b0;
    int          enable_count = 0;
    int          st_cnt = 0;
    bit          st_act = 1'b0;
    logic [NB-1:0] st_a, st_b, st_m;

    mulpool_sched #(.NBITS(NB), .PBITS(PB), .NREQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .m(m), .rsp_valid(rsp_valid),
        .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id),
        .mm_enable_p(mm_enable_p), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_mx3(mm_mx3), .mm_y(mm_y), .mm_done_p(mm_done_p)
    );

    always #5 clk = ~clk;

    function automatic logic [NB-1:0] mod_mul(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                              input logic [NB-1:0] mm);
        longint p;
        if (mm == '0) return '0;
        p = (longint'(a) * longint'(b)) % longint'(mm);
        return NB'(p);
    endfunction

    function automatic int next_grant(input logic [NR-1:0] mask, input int ptr);
        int c;
        for (int i = 0; i < NR; i++) begin
            c = (ptr + i) % NR;
            if (mask[c[1:0]]) return c;
        end
        return -1;
    endfunction

    // Behavioural multiplier: latches operands on enable, answers after a delay.
    always @(negedge clk) begin
        mm_done_p = 1'b0;
        if (late_pulse) begin
            mm_done_p  = 1'b1;
            mm_y       = 16'h1234;
            late_pulse = 1'b0;
        end else if (mm_enable_p) begin
            enable_count++;
            st_a = mm_a; st_b = mm_b; st_m = mm_m;
            st_cnt = (stub_lat < 0) ? int'($urandom_range(12, 0)) : stub_lat;
            st_act = !stub_hang;
        end else if (st_act) begin
            if (st_cnt == 0) begin
                mm_done_p = 1'b1;
                mm_y      = mod_mul(st_a, st_b, st_m);
                st_act    = 1'b0;
            end else begin
                st_cnt--;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_op(input int idx, input logic [NB-1:0] a, input logic [NB-1:0] b);
        req_a[idx*NB +: NB] = a;
        req_b[idx*NB +: NB] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0;
        tick(); tick();
        rst = 1'b0; exp_ptr = 0;
    endtask

    // Wait (bounded) for a non-zero req_ready; the accept edge follows.
    task automatic wait_accept(output logic [NR-1:0] rdy, output logic ok, output int waited);
        ok = 1'b0; rdy = '0; waited = 0;
        #1;
        for (int i = 0; i < 12 && !ok; i++) begin
            if (req_ready != '0) begin
                rdy = req_ready; ok = 1'b1;
            end else begin
                tick(); #1; waited++;
            end
        end
    endtask

    // Wait (bounded) for rsp_valid, counting cycles from ISSUE.
    task automatic wait_resp(output int cycles, output logic ok, output logic [NR-1:0] rdy_or);
        ok = 1'b0; cycles = 0; rdy_or = '0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick(); cycles++;
            rdy_or |= req_ready;
            if (rsp_valid != '0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy, req_ready, rsp_valid, rsp_err, mm_enable_p, grant_id} !== '0) begin
            bad++; $display("FAIL reset_ctrl: got %h want 0",
                            {busy, req_ready, rsp_valid, rsp_err, mm_enable_p, grant_id});
        end
        total++;
        if ({rsp_y, mm_a, mm_b, mm_m, mm_mx3} !== '0) begin
            bad++; $display("FAIL reset_data: got %h want 0", {rsp_y, mm_a, mm_b, mm_m, mm_mx3});
        end
    endtask

    task automatic test_single_op();
        logic [NR-1:0] rdy, ro; logic ok; int w, cyc, e0;
        m = 16'd97; set_op(0, 16'd10, 16'd20); req_valid = 4'b0001;
        wait_accept(rdy, ok, w);
        total++;
        if (!ok || rdy !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b want 0001", rdy); end
        e0 = enable_count;
        tick(); req_valid = '0;
        total++;
        if ({mm_enable_p, grant_id, busy} !== 4'b1001) begin
            bad++; $display("FAIL single_issue: got %b want 1001", {mm_enable_p, grant_id, busy});
        end
        total++;
        if (mm_mx3 !== 18'd291 || mm_a !== 16'd10 || mm_b !== 16'd20 || mm_m !== 16'd97) begin
            bad++; $display("FAIL single_operands: got mx3=%0d a=%0d b=%0d m=%0d want 291 10 20 97",
                            mm_mx3, mm_a, mm_b, mm_m);
        end
        wait_resp(cyc, ok, ro);
        total++;
        if (!ok || rsp_valid !== 4'b0001 || rsp_y !== 16'd6 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL single_rsp: got v=%b y=%0d e=%b want 0001 6 0", rsp_valid, rsp_y, rsp_err);
        end
        total++;
        if (enable_count - e0 != 1) begin
            bad++; $display("FAIL single_enable_count: got %0d want 1", enable_count - e0);
        end
        tick();
        total++;
        if (rsp_valid !== 4'b0000 || rsp_y !== 16'd6 || busy !== 1'b0) begin
            bad++; $display("FAIL single_hold: got v=%b y=%0d busy=%b want 0000 6 0", rsp_valid, rsp_y, busy);
        end
        exp_ptr = 1;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] rdy, ro; logic ok; int w, cyc, g;
        logic [NB-1:0] ta [NR]; logic [NB-1:0] tb [NR];
        do_reset();
        m = NB'($urandom_range(65535, 1000));
        for (int i = 0; i < NR; i++) begin
            ta[i] = NB'($urandom_range(int'(m) - 1, 0));
            tb[i] = NB'($urandom_range(int'(m) - 1, 0));
            set_op(i, ta[i], tb[i]);
        end
        req_valid = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            g = next_grant(4'b1101, exp_ptr);
            wait_accept(rdy, ok, w);
            total++;
            if (!ok || rdy !== (4'b0001 << g) || (k > 0 && w != 0)) begin
                bad++; $display("FAIL rr_ready[%0d]: got %b after %0d want %b", k, rdy, w, 4'b0001 << g);
            end
            tick();
            total++;
            if (grant_id !== 2'(g)) begin bad++; $display("FAIL rr_grant_id[%0d]: got %0d want %0d", k, grant_id, g); end
            wait_resp(cyc, ok, ro);
            total++;
            if (!ok || rsp_valid !== (4'b0001 << g) || rsp_y !== mod_mul(ta[g], tb[g], m) || rsp_err !== 1'b0) begin
                bad++; $display("FAIL rr_rsp[%0d]: got v=%b y=%h want %b %h", k, rsp_valid, rsp_y,
                                4'b0001 << g, mod_mul(ta[g], tb[g], m));
            end
            total++;
            if (ro !== '0) begin bad++; $display("FAIL rr_ready_busy[%0d]: got %b want 0000", k, ro); end
            exp_ptr = (g + 1) % NR;
            if (k == 3) req_valid = '0;
            tick();
        end
    endtask

    task automatic test_isolation();
        logic [NR-1:0] rdy, ro; logic ok; int w, cyc;
        stub_lat = 8; m = 16'd97; set_op(1, 16'd50, 16'd3); req_valid = 4'b0010;
        wait_accept(rdy, ok, w);
        tick(); req_valid = '0;
        tick(); tick();
        m = 16'd101; set_op(1, 16'd77, 16'd3);
        tick();
        total++;
        if (mm_m !== 16'd97 || mm_a !== 16'd50) begin
            bad++; $display("FAIL iso_regs: got m=%0d a=%0d want 97 50", mm_m, mm_a);
        end
        wait_resp(cyc, ok, ro);
        total++;
        if (!ok || rsp_valid !== 4'b0010 || rsp_y !== 16'd53 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL iso_rsp: got v=%b y=%0d e=%b want 0010 53 0", rsp_valid, rsp_y, rsp_err);
        end
        stub_lat = -1; exp_ptr = 2;
        tick();
    endtask

    task automatic test_timeout();
        logic [NR-1:0] rdy, ro, seen; logic ok; int w, cyc; logic [NB-1:0] ea, eb;
        // hung multiplier, then a late done pulse
        stub_hang = 1'b1; m = 16'd97; set_op(2, 16'd33, 16'd44); req_valid = 4'b0100;
        wait_accept(rdy, ok, w);
        tick(); req_valid = '0;
        wait_resp(cyc, ok, ro);
        total++;
        if (!ok || cyc != TO + 1 || rsp_valid !== 4'b0100 || rsp_y !== '0 || rsp_err !== 1'b1) begin
            bad++; $display("FAIL timeout_rsp: got cyc=%0d v=%b y=%h e=%b want %0d 0100 0 1",
                            cyc, rsp_valid, rsp_y, rsp_err, TO + 1);
        end
        stub_hang = 1'b0;
        tick(); late_pulse = 1'b1; seen = '0;
        for (int i = 0; i < 5; i++) begin tick(); seen |= rsp_valid; end
        total++;
        if (seen !== '0 || busy !== 1'b0 || rsp_err !== 1'b1 || rsp_y !== '0) begin
            bad++; $display("FAIL timeout_late_done: got v=%b busy=%b e=%b y=%h want 0 0 1 0", seen, busy, rsp_err, rsp_y);
        end
        // done arriving in the very cycle the watchdog expires wins
        stub_lat = TO - 1; ea = 16'd12; eb = 16'd34; set_op(3, ea, eb); req_valid = 4'b1000;
        wait_accept(rdy, ok, w);
        tick(); req_valid = '0;
        wait_resp(cyc, ok, ro);
        total++;
        if (!ok || cyc != TO + 1 || rsp_valid !== 4'b1000 || rsp_y !== mod_mul(ea, eb, m) || rsp_err !== 1'b0) begin
            bad++; $display("FAIL timeout_done_wins: got cyc=%0d v=%b y=%0d e=%b want %0d 1000 %0d 0",
                            cyc, rsp_valid, rsp_y, rsp_err, TO + 1, mod_mul(ea, eb, m));
        end
        tick();
        // done one cycle too late: error, and the pulse in RESP is ignored
        stub_lat = TO; set_op(0, ea, eb); req_valid = 4'b0001;
        wait_accept(rdy, ok, w);
        tick(); req_valid = '0;
        wait_resp(cyc, ok, ro);
        total++;
        if (!ok || cyc != TO + 1 || rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_y !== '0) begin
            bad++; $display("FAIL timeout_one_late: got cyc=%0d v=%b y=%h e=%b want %0d 0001 0 1",
                            cyc, rsp_valid, rsp_y, rsp_err, TO + 1);
        end
        seen = '0;
        for (int i = 0; i < 4; i++) begin tick(); seen |= rsp_valid; end
        total++;
        if (seen !== '0 || busy !== 1'b0) begin
            bad++; $display("FAIL timeout_ignored: got v=%b busy=%b want 0 0", seen, busy);
        end
        stub_lat = -1; exp_ptr = 1;
    endtask

    task automatic test_reset_mid_wait();
        logic [NR-1:0] rdy, ro, seen; logic ok; int w, cyc; logic [NB-1:0] ea, eb;
        stub_lat = 15; m = 16'd97; set_op(3, 16'd7, 16'd8); req_valid = 4'b1000;
        wait_accept(rdy, ok, w);
        tick(); req_valid = '0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, req_ready, rsp_valid, rsp_err, mm_enable_p, grant_id} !== '0) begin
            bad++; $display("FAIL midwait_ctrl: got %h want 0",
                            {busy, req_ready, rsp_valid, rsp_err, mm_enable_p, grant_id});
        end
        total++;
        if ({rsp_y, mm_a, mm_b, mm_m, mm_mx3} !== '0) begin
            bad++; $display("FAIL midwait_data: got %h want 0", {rsp_y, mm_a, mm_b, mm_m, mm_mx3});
        end
        seen = '0;
        for (int i = 0; i < 20; i++) begin tick(); seen |= rsp_valid; end
        total++;
        if (seen !== '0) begin bad++; $display("FAIL midwait_no_rsp: got %b want 0000", seen); end
        stub_lat = -1; exp_ptr = 0;
        ea = 16'd90; eb = 16'd91;
        for (int i = 0; i < NR; i++) set_op(i, ea, eb);
        req_valid = 4'b1111;
        wait_accept(rdy, ok, w);
        total++;
        if (!ok || rdy !== 4'b0001) begin bad++; $display("FAIL midwait_ptr: got %b want 0001", rdy); end
        tick(); req_valid = '0;
        wait_resp(cyc, ok, ro);
        total++;
        if (!ok || rsp_valid !== 4'b0001 || rsp_y !== mod_mul(ea, eb, m)) begin
            bad++; $display("FAIL midwait_after: got v=%b y=%0d want 0001 %0d", rsp_valid, rsp_y, mod_mul(ea, eb, m));
        end
        exp_ptr = 1;
        tick();
    endtask

    task automatic test_zero();
        logic [NR-1:0] rdy, ro; logic ok; int w, cyc;
        m = 16'd97; set_op(2, 16'd0, 16'd55); req_valid = 4'b0100;
        wait_accept(rdy, ok, w);
        tick(); req_valid = '0;
        wait_resp(cyc, ok, ro);
        total++;
        if (!ok || rsp_valid !== 4'b0100 || rsp_y !== 16'd0 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL zero_rsp: got v=%b y=%0d e=%b want 0100 0 0", rsp_valid, rsp_y, rsp_err);
        end
        exp_ptr = 3;
        tick();
    endtask

    task automatic test_random();
        logic [NR-1:0] rdy, ro, mask; logic ok; int w, cyc, g;
        logic [NB-1:0] ta [NR]; logic [NB-1:0] tb [NR];
        for (int n = 0; n < 25; n++) begin
            mask = NR'($urandom_range(15, 1));
            m = NB'($urandom_range(65535, 2));
            for (int i = 0; i < NR; i++) begin
                ta[i] = ($urandom_range(3, 0) == 0) ? '0 : NB'($urandom_range(int'(m) - 1, 0));
                tb[i] = NB'($urandom_range(int'(m) - 1, 0));
                set_op(i, ta[i], tb[i]);
            end
            g = next_grant(mask, exp_ptr);
            req_valid = mask;
            wait_accept(rdy, ok, w);
            total++;
            if (!ok || rdy !== (4'b0001 << g)) begin
                bad++; $display("FAIL rand_ready[%0d]: got %b want %b", n, rdy, 4'b0001 << g);
            end
            tick(); req_valid = '0;
            wait_resp(cyc, ok, ro);
            total++;
            if (!ok || rsp_valid !== (4'b0001 << g) || rsp_y !== mod_mul(ta[g], tb[g], m) || rsp_err !== 1'b0) begin
                bad++; $display("FAIL rand_rsp[%0d]: got v=%b y=%h e=%b want %b %h 0", n, rsp_valid, rsp_y,
                                rsp_err, 4'b0001 << g, mod_mul(ta[g], tb[g], m));
            end
            exp_ptr = (g + 1) % NR;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; m = '0;
        mm_y = '0; mm_done_p = 1'b0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_isolation();
        test_timeout();
        test_reset_mid_wait();
        test_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
